// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: one-entry skid register between rename and the ALU/branch/LSU
// reservation stations. It steers the held instruction by its fu field, gates
// dispatch on ROB space and the target station's full flag, and owns the
// physical-register ready table that the stations read for wakeup.

package dispatch_pkg;
  localparam int RD_PREG_W = 7;

  typedef struct packed {
    logic [31:0]          pc;
    logic [4:0]           rob_tag;
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [1:0]           fu;
    logic [RD_PREG_W-1:0] pd_new;
    logic [RD_PREG_W-1:0] ps1;
    logic [RD_PREG_W-1:0] ps2;
    logic [31:0]          imm;
  } rename_data;
endpackage

module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int NUM_PREG = 128,
  parameter int PREG_W   = 7,
  parameter int NUM_RS   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rn_valid,
  input  rename_data          rn_data,
  output logic                rn_ready,
  input  logic                rob_full,
  output logic                rob_alloc,
  input  logic [NUM_RS-1:0]   rs_full,
  output logic [NUM_RS-1:0]   di_en,
  output rename_data          r_data,
  input  logic                cdb_valid,
  input  logic [PREG_W-1:0]   cdb_pd,
  input  logic                mispredict,
  output logic [NUM_PREG-1:0] preg_rtable,
  output logic [31:0]         stall_cycles
);

  rename_data          r_buf;
  logic                r_buf_valid;
  logic [31:0]         r_stall_cycles;
  logic [NUM_PREG-1:0] r_rtable;

  logic w_fu_ok;
  logic w_rs_blk;
  logic w_fire;
  logic w_capture;
  logic w_writes_rd;

  // Look up the target station's full flag; an out-of-range fu never matches,
  // so the instruction stays blocked and is counted as a stall.
  always_comb begin
    w_fu_ok  = 1'b0;
    w_rs_blk = 1'b1;
    for (int i = 0; i < NUM_RS; i++) begin
      if (int'(r_buf.fu) == i) begin
        w_fu_ok  = 1'b1;
        w_rs_blk = rs_full[i];
      end
    end
  end

  assign w_fire      = r_buf_valid && !rob_full && !w_rs_blk && !mispredict && w_fu_ok;
  // During a mispredict rename is flushing too, so nothing is accepted.
  assign rn_ready    = !mispredict && (!r_buf_valid || w_fire);
  assign w_capture   = rn_valid && rn_ready;
  assign w_writes_rd = (r_buf.opcode != 7'h23) && (r_buf.opcode != 7'h63);
  assign rob_alloc   = w_fire;

  // One-hot enable to the selected station, same cycle as fire.
  always_comb begin
    di_en = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      di_en[i] = w_fire && (int'(r_buf.fu) == i);
    end
  end

  // Stations see zeros when nothing is held, so a stale entry never leaks out.
  assign r_data = r_buf_valid ? r_buf : '0;

  // Skid register: load on accept, drop on fire, flush on mispredict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
    end else if (mispredict) begin
      r_buf_valid <= 1'b0;
    end else if (w_capture) begin
      r_buf_valid <= 1'b1;
      r_buf       <= rn_data;
    end else if (w_fire) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Saturating count of cycles where a held instruction could not go.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (r_buf_valid && !w_fire && !mispredict && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

  // Ready table: writeback sets, dispatch of a new destination clears. The
  // clear is written last so it wins when both hit the same preg. Preg 0 is
  // never written and stays ready from reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rtable <= '1;
    end else begin
      if (cdb_valid && (cdb_pd != '0)) begin
        r_rtable[cdb_pd] <= 1'b1;
      end
      if (w_fire && w_writes_rd && (r_buf.pd_new != '0)) begin
        r_rtable[r_buf.pd_new] <= 1'b0;
      end
    end
  end

  assign preg_rtable = r_rtable;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: a per-cycle vector table for the steady
// dispatch/backpressure/ready-table cases, then hand sequences for
// mispredict flush, illegal fu and asynchronous reset mid-stall.
module tb_dispatch_ctrl;
  import dispatch_pkg::*;

  localparam int NUM_PREG = 128;
  localparam int PREG_W   = 7;
  localparam int NUM_RS   = 3;

  logic                clk;
  logic                reset;
  logic                rn_valid;
  rename_data          rn_data;
  logic                rn_ready;
  logic                rob_full;
  logic                rob_alloc;
  logic [NUM_RS-1:0]   rs_full;
  logic [NUM_RS-1:0]   di_en;
  rename_data          r_data;
  logic                cdb_valid;
  logic [PREG_W-1:0]   cdb_pd;
  logic                mispredict;
  logic [NUM_PREG-1:0] preg_rtable;
  logic [31:0]         stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  dispatch_ctrl #(.NUM_PREG(NUM_PREG), .PREG_W(PREG_W), .NUM_RS(NUM_RS)) dut (
    .clk(clk), .reset(reset),
    .rn_valid(rn_valid), .rn_data(rn_data), .rn_ready(rn_ready),
    .rob_full(rob_full), .rob_alloc(rob_alloc),
    .rs_full(rs_full), .di_en(di_en), .r_data(r_data),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .mispredict(mispredict),
    .preg_rtable(preg_rtable), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn_valid;
    logic [31:0] pc;
    logic [1:0]  fu;
    logic [6:0]  op;
    logic [6:0]  pd;
    logic        rob_full;
    logic [2:0]  rs_full;
    logic        cdb_v;
    logic [6:0]  cdb_pd;
    logic        e_rdy;
    logic [2:0]  e_di;
    logic        e_alloc;
    logic [31:0] e_pc;
    logic [31:0] e_stall;
    int          rt_idx;
    logic        e_rt;
  } vec_t;

  vec_t tbl[$];

  function automatic rename_data mk(input logic [31:0] pc, input logic [1:0] fu,
                                    input logic [6:0] op, input logic [6:0] pd);
    rename_data d;
    d         = '0;
    d.pc      = pc;
    d.rob_tag = pc[6:2];
    d.opcode  = op;
    d.fu      = fu;
    d.pd_new  = pd;
    d.ps1     = 7'd1;
    d.ps2     = 7'd2;
    d.imm     = pc ^ 32'h5A5A_0000;
    return d;
  endfunction

  function automatic vec_t V(input logic rv, input logic [31:0] pc, input logic [1:0] fu,
                             input logic [6:0] op, input logic [6:0] pd, input logic rf,
                             input logic [2:0] rs, input logic cv, input logic [6:0] cp,
                             input logic er, input logic [2:0] ed, input logic ea,
                             input logic [31:0] ep, input logic [31:0] es,
                             input int ri, input logic ert);
    vec_t v;
    v.rn_valid = rv; v.pc = pc; v.fu = fu; v.op = op; v.pd = pd;
    v.rob_full = rf; v.rs_full = rs; v.cdb_v = cv; v.cdb_pd = cp;
    v.e_rdy = er; v.e_di = ed; v.e_alloc = ea; v.e_pc = ep; v.e_stall = es;
    v.rt_idx = ri; v.e_rt = ert;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic v, input rename_data d);
    rn_valid = v;
    rn_data  = v ? d : '0;
  endtask

  initial begin
    reset = 1'b1; rn_valid = 1'b0; rn_data = '0; rob_full = 1'b0; rs_full = '0;
    cdb_valid = 1'b0; cdb_pd = '0; mispredict = 1'b0;

    // Stimulus table: one row per cycle, expectations sampled before the edge.
    // T1: back-to-back fu 0,1,2
    tbl.push_back(V(1,'h100,0,7'h33,5,  0,3'b000,0,0, 1,3'b000,0,'h000,0,  5,1));
    tbl.push_back(V(1,'h104,1,7'h33,0,  0,3'b000,0,0, 1,3'b001,1,'h100,0, -1,0));
    tbl.push_back(V(1,'h108,2,7'h33,9,  0,3'b000,0,0, 1,3'b010,1,'h104,0,  5,0));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,0,0, 1,3'b100,1,'h108,0,  0,1));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,0,0, 1,3'b000,0,'h000,0,  9,0));
    // T2: ALU held under rs_full[0] for 4 cycles
    tbl.push_back(V(1,'h200,0,7'h33,20, 0,3'b001,0,0, 1,3'b000,0,'h000,0, -1,0));
    tbl.push_back(V(1,'h204,1,7'h33,21, 0,3'b001,0,0, 0,3'b000,0,'h200,0, -1,0));
    tbl.push_back(V(1,'h204,1,7'h33,21, 0,3'b001,0,0, 0,3'b000,0,'h200,1, -1,0));
    tbl.push_back(V(1,'h204,1,7'h33,21, 0,3'b001,0,0, 0,3'b000,0,'h200,2, -1,0));
    tbl.push_back(V(1,'h204,1,7'h33,21, 0,3'b001,0,0, 0,3'b000,0,'h200,3, -1,0));
    tbl.push_back(V(1,'h204,1,7'h33,21, 0,3'b000,0,0, 1,3'b001,1,'h200,4, 20,1));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,0,0, 1,3'b010,1,'h204,4, 20,0));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,0,0, 1,3'b000,0,'h000,4, 21,0));
    // T3: branch held under rob_full; branches do not clear their pd
    tbl.push_back(V(1,'h300,1,7'h63,30, 1,3'b000,0,0, 1,3'b000,0,'h000,4, -1,0));
    tbl.push_back(V(0,'h000,0,7'h00,0,  1,3'b000,0,0, 0,3'b000,0,'h300,4, -1,0));
    tbl.push_back(V(0,'h000,0,7'h00,0,  1,3'b000,0,0, 0,3'b000,0,'h300,5, -1,0));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,0,0, 1,3'b010,1,'h300,6, -1,0));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,0,0, 1,3'b000,0,'h000,6, 30,1));
    // T4: dispatch clear beats same-cycle CDB set
    tbl.push_back(V(1,'h400,0,7'h33,12, 0,3'b000,0,0,  1,3'b000,0,'h000,6, 12,1));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,1,12, 1,3'b001,1,'h400,6, 12,1));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,1,12, 1,3'b000,0,'h000,6, 12,0));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,1,5,  1,3'b000,0,'h000,6, 12,1));
    tbl.push_back(V(0,'h000,0,7'h00,0,  0,3'b000,0,0,  1,3'b000,0,'h000,6,  5,1));

    // Reset state
    #3;
    chk("rst_rn_ready", 128'(rn_ready), 128'(1));
    chk("rst_di_en", 128'(di_en), 128'(0));
    chk("rst_rob_alloc", 128'(rob_alloc), 128'(0));
    chk("rst_r_data", 128'(r_data), 128'(0));
    chk("rst_stall", 128'(stall_cycles), 128'(0));
    chk("rst_rtable", 128'(preg_rtable), {128{1'b1}});
    @(negedge clk); reset = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      send(tbl[k].rn_valid, mk(tbl[k].pc, tbl[k].fu, tbl[k].op, tbl[k].pd));
      rob_full = tbl[k].rob_full; rs_full = tbl[k].rs_full;
      cdb_valid = tbl[k].cdb_v; cdb_pd = tbl[k].cdb_pd;
      #1;
      chk($sformatf("v%0d_rn_ready", k), 128'(rn_ready), 128'(tbl[k].e_rdy));
      chk($sformatf("v%0d_di_en", k), 128'(di_en), 128'(tbl[k].e_di));
      chk($sformatf("v%0d_rob_alloc", k), 128'(rob_alloc), 128'(tbl[k].e_alloc));
      chk($sformatf("v%0d_r_data_pc", k), 128'(r_data.pc), 128'(tbl[k].e_pc));
      chk($sformatf("v%0d_stall", k), 128'(stall_cycles), 128'(tbl[k].e_stall));
      if (tbl[k].rt_idx >= 0)
        chk($sformatf("v%0d_rtable[%0d]", k, tbl[k].rt_idx), 128'(preg_rtable[tbl[k].rt_idx]), 128'(tbl[k].e_rt));
    end

    // Seq A: mispredict while held under rs_full; would-be fire is suppressed
    @(negedge clk); send(1, mk('h500, 2, 7'h33, 40)); rs_full = 3'b100; cdb_valid = 0;
    @(negedge clk); send(0, '0); #1;
    chk("mpA_held_pc", 128'(r_data.pc), 128'('h500));
    chk("mpA_stall0", 128'(stall_cycles), 128'(6));
    @(negedge clk); mispredict = 1; rs_full = 3'b000; send(1, mk('h600, 0, 7'h33, 41)); #1;
    chk("mpA_rn_ready", 128'(rn_ready), 128'(0));
    chk("mpA_di_en", 128'(di_en), 128'(0));
    chk("mpA_rob_alloc", 128'(rob_alloc), 128'(0));
    chk("mpA_stall1", 128'(stall_cycles), 128'(7));
    @(negedge clk); mispredict = 0; send(1, mk('h700, 0, 7'h33, 42)); #1;
    chk("mpA_flushed_pc", 128'(r_data.pc), 128'(0));
    chk("mpA_after_di", 128'(di_en), 128'(0));
    chk("mpA_after_rdy", 128'(rn_ready), 128'(1));
    chk("mpA_stall2", 128'(stall_cycles), 128'(7));
    @(negedge clk); send(0, '0); #1;
    chk("mpA_next_di", 128'(di_en), 128'(3'b001));
    chk("mpA_next_pc", 128'(r_data.pc), 128'('h700));
    chk("mpA_rt40", 128'(preg_rtable[40]), 128'(1));
    @(negedge clk); #1;
    chk("mpA_idle_di", 128'(di_en), 128'(0));
    chk("mpA_rt42", 128'(preg_rtable[42]), 128'(0));
    chk("mpA_rt41", 128'(preg_rtable[41]), 128'(1));

    // Seq B: illegal fu holds forever and counts stalls until flushed
    @(negedge clk); send(1, mk('h800, 3, 7'h33, 44));
    @(negedge clk); send(0, '0); #1;
    chk("ilB_rdy", 128'(rn_ready), 128'(0));
    chk("ilB_di", 128'(di_en), 128'(0));
    chk("ilB_alloc", 128'(rob_alloc), 128'(0));
    chk("ilB_pc", 128'(r_data.pc), 128'('h800));
    chk("ilB_stall0", 128'(stall_cycles), 128'(7));
    @(negedge clk); #1;
    chk("ilB_stall1", 128'(stall_cycles), 128'(8));
    chk("ilB_di1", 128'(di_en), 128'(0));
    @(negedge clk); mispredict = 1; send(1, mk('h600, 0, 7'h33, 41)); #1;
    chk("ilB_stall2", 128'(stall_cycles), 128'(9));
    chk("ilB_mp_rdy", 128'(rn_ready), 128'(0));
    @(negedge clk); #1;
    chk("ilB_mp2_rdy", 128'(rn_ready), 128'(0));
    chk("ilB_mp2_pc", 128'(r_data.pc), 128'(0));
    chk("ilB_mp2_stall", 128'(stall_cycles), 128'(9));
    @(negedge clk); mispredict = 0; send(0, '0); #1;
    chk("ilB_drop_pc", 128'(r_data.pc), 128'(0));
    chk("ilB_drop_rdy", 128'(rn_ready), 128'(1));

    // Seq C: asynchronous reset mid-stall with a dispatch about to fire
    @(negedge clk); send(1, mk('h900, 0, 7'h33, 50)); rs_full = 3'b001;
    @(negedge clk); send(0, '0); #1;
    chk("rsC_pc", 128'(r_data.pc), 128'('h900));
    chk("rsC_stall0", 128'(stall_cycles), 128'(9));
    @(negedge clk); #1;
    chk("rsC_stall1", 128'(stall_cycles), 128'(10));
    chk("rsC_rt42", 128'(preg_rtable[42]), 128'(0));
    @(negedge clk); rs_full = 3'b000; #1;
    chk("rsC_pre_di", 128'(di_en), 128'(3'b001));
    #1 reset = 1'b1; #1;
    chk("rsC_rdy", 128'(rn_ready), 128'(1));
    chk("rsC_di", 128'(di_en), 128'(0));
    chk("rsC_alloc", 128'(rob_alloc), 128'(0));
    chk("rsC_r_data", 128'(r_data), 128'(0));
    chk("rsC_stall", 128'(stall_cycles), 128'(0));
    chk("rsC_rtable", 128'(preg_rtable), {128{1'b1}});
    @(negedge clk); reset = 1'b0; #1;
    chk("rsC_post_di", 128'(di_en), 128'(0));
    chk("rsC_post_pc", 128'(r_data.pc), 128'(0));
    chk("rsC_post_rt50", 128'(preg_rtable[50]), 128'(1));
    @(negedge clk); send(1, mk('hA00, 1, 7'h33, 3));
    @(negedge clk); send(0, '0); #1;
    chk("rsC_resume_di", 128'(di_en), 128'(3'b010));
    chk("rsC_resume_pc", 128'(r_data.pc), 128'('hA00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
